// File: rtl/rename_map_table_pkg.sv
// Shared widths and types for the register rename map and its bench.
package rename_map_table_pkg;

    localparam int REN_WIDTH    = 2;
    localparam int REN_NUM_ARCH = 16;
    localparam int REN_NUM_PHYS = 64;
    localparam int REN_NUM_CKPT = 4;
    localparam int REN_AW       = $clog2(REN_NUM_ARCH);
    localparam int REN_PW       = $clog2(REN_NUM_PHYS);
    localparam int REN_CW       = $clog2(REN_NUM_CKPT);

    typedef logic [REN_AW-1:0] arch_reg_t;
    typedef logic [REN_PW-1:0] phys_reg_t;
    typedef logic [REN_CW-1:0] ckpt_id_t;

    typedef struct packed {
        logic      valid;
        arch_reg_t ra;
        arch_reg_t rt;
        arch_reg_t rw;
        logic      use_rw;
        logic      br;
        phys_reg_t new_p;
    } rename_lane_t;

endpackage

// File: rtl/rename_bypass.sv
// Per-lane intra-group forwarding: older lanes' fresh mappings override the map.
// RENAME_ZERO_REG_EN pins arch r0 to phys 0.
module rename_bypass
    import rename_map_table_pkg::*;
#(
    parameter int LANE  = 0,
    parameter int WIDTH = REN_WIDTH,
    parameter int AW    = REN_AW,
    parameter int PW    = REN_PW
) (
    input  logic [WIDTH-1:0]    grp_valid,
    input  logic [WIDTH-1:0]    grp_use_rw,
    input  logic [WIDTH*AW-1:0] grp_rw,
    input  logic [WIDTH*PW-1:0] grp_new_p,
    input  logic [AW-1:0]       ra,
    input  logic [AW-1:0]       rt,
    input  logic [AW-1:0]       rw,
    input  logic [PW-1:0]       map_ra,
    input  logic [PW-1:0]       map_rt,
    input  logic [PW-1:0]       map_rw,
    output logic [PW-1:0]       p_ra,
    output logic [PW-1:0]       p_rt,
    output logic [PW-1:0]       p_old_rw
);

    // Walk older lanes oldest-first so the newest matching writer wins.
    function automatic logic [PW-1:0] lookup(input logic [AW-1:0] q,
                                             input logic [PW-1:0] base);
        logic [PW-1:0] r;
        r = base;
        for (int i = 0; i < LANE; i++) begin
            if (grp_valid[i] && grp_use_rw[i] && (grp_rw[i*AW +: AW] == q))
                r = grp_new_p[i*PW +: PW];
        end
`ifdef RENAME_ZERO_REG_EN
        if (q == '0)
            r = '0;
`endif
        return r;
    endfunction

    always_comb begin
        p_ra     = lookup(ra, map_ra);
        p_rt     = lookup(rt, map_rt);
        p_old_rw = lookup(rw, map_rw);
    end

endmodule

// File: rtl/rename_map_table.sv
// Superscalar rename map with a ring of branch checkpoints for one-cycle recovery.
// RENAME_ZERO_REG_EN: arch r0 hardwired to phys 0 (writes ignored).
module rename_map_table
    import rename_map_table_pkg::*;
#(
    parameter int WIDTH    = REN_WIDTH,
    parameter int NUM_ARCH = REN_NUM_ARCH,
    parameter int NUM_PHYS = REN_NUM_PHYS,
    parameter int NUM_CKPT = REN_NUM_CKPT,
    parameter int AW       = $clog2(NUM_ARCH),
    parameter int PW       = $clog2(NUM_PHYS),
    parameter int CW       = $clog2(NUM_CKPT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    ren_valid_i,
    input  logic [WIDTH*AW-1:0] ren_ra_i,
    input  logic [WIDTH*AW-1:0] ren_rt_i,
    input  logic [WIDTH*AW-1:0] ren_rw_i,
    input  logic [WIDTH-1:0]    ren_use_rw_i,
    input  logic [WIDTH*PW-1:0] ren_new_p_i,
    input  logic [WIDTH-1:0]    ren_br_i,
    output logic                ren_ready_o,
    output logic [WIDTH*PW-1:0] p_ra_o,
    output logic [WIDTH*PW-1:0] p_rt_o,
    output logic [WIDTH*PW-1:0] p_old_rw_o,
    output logic [CW-1:0]       ckpt_id_o,
    input  logic                br_resolve_i,
    input  logic                br_mispredict_i,
    input  logic [CW-1:0]       br_ckpt_i,
    output logic [CW:0]         ckpt_count_o
);

    localparam logic [CW:0] CKPT_FULL = (CW+1)'(NUM_CKPT);

    logic [PW-1:0] map_reg  [NUM_ARCH];
    logic [PW-1:0] ckpt_reg [NUM_CKPT][NUM_ARCH];
    logic [PW-1:0] map_next [NUM_ARCH];
    logic [PW-1:0] snap_next[NUM_ARCH];
    logic [CW-1:0] head_reg, tail_reg, head_next, tail_next;
    logic [CW:0]   count_reg, count_next;

    logic [AW-1:0]    ra_a [WIDTH];
    logic [AW-1:0]    rt_a [WIDTH];
    logic [AW-1:0]    rw_a [WIDTH];
    logic [PW-1:0]    new_p_a [WIDTH];
    logic [WIDTH-1:0] lane_wr;
    logic [WIDTH-1:0] in_snap;
    logic             fire, take_ckpt;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign ra_a[gi]    = ren_ra_i[gi*AW +: AW];
            assign rt_a[gi]    = ren_rt_i[gi*AW +: AW];
            assign rw_a[gi]    = ren_rw_i[gi*AW +: AW];
            assign new_p_a[gi] = ren_new_p_i[gi*PW +: PW];
`ifdef RENAME_ZERO_REG_EN
            assign lane_wr[gi] = ren_valid_i[gi] && ren_use_rw_i[gi] && (rw_a[gi] != '0);
`else
            assign lane_wr[gi] = ren_valid_i[gi] && ren_use_rw_i[gi];
`endif

            rename_bypass #(
                .LANE  (gi),
                .WIDTH (WIDTH),
                .AW    (AW),
                .PW    (PW)
            ) u_bypass (
                .grp_valid  (ren_valid_i),
                .grp_use_rw (ren_use_rw_i),
                .grp_rw     (ren_rw_i),
                .grp_new_p  (ren_new_p_i),
                .ra         (ra_a[gi]),
                .rt         (rt_a[gi]),
                .rw         (rw_a[gi]),
                .map_ra     (map_reg[ra_a[gi]]),
                .map_rt     (map_reg[rt_a[gi]]),
                .map_rw     (map_reg[rw_a[gi]]),
                .p_ra       (p_ra_o[gi*PW +: PW]),
                .p_rt       (p_rt_o[gi*PW +: PW]),
                .p_old_rw   (p_old_rw_o[gi*PW +: PW])
            );
        end
    endgenerate

    assign ren_ready_o  = !br_mispredict_i && ((count_reg < CKPT_FULL) || !(|ren_br_i));
    assign fire         = ren_ready_o && (|ren_valid_i);
    assign take_ckpt    = fire && (|(ren_br_i & ren_valid_i));
    assign ckpt_id_o    = tail_reg;
    assign ckpt_count_o = count_reg;

    // A lane belongs in the checkpoint unless a branch sits in an older lane.
    always_comb begin
        logic br_seen;
        br_seen = 1'b0;
        in_snap = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_snap[i] = !br_seen;
            br_seen    = br_seen | (ren_valid_i[i] & ren_br_i[i]);
        end
    end

    always_comb begin
        for (int a = 0; a < NUM_ARCH; a++) begin
            map_next[a]  = map_reg[a];
            snap_next[a] = map_reg[a];
            for (int i = 0; i < WIDTH; i++) begin
                if (lane_wr[i] && (rw_a[i] == AW'(a))) begin
                    map_next[a] = new_p_a[i];
                    if (in_snap[i])
                        snap_next[a] = new_p_a[i];
                end
            end
        end
    end

    // A resolve advances head before a same-cycle mispredict trims the tail.
    always_comb begin
        head_next  = head_reg + CW'(br_resolve_i);
        tail_next  = tail_reg;
        count_next = count_reg;
        if (br_mispredict_i) begin
            tail_next  = br_ckpt_i;
            count_next = {1'b0, CW'(br_ckpt_i - head_next)};
        end else begin
            if (take_ckpt)
                tail_next = tail_reg + CW'(1);
            count_next = count_reg + (CW+1)'(take_ckpt) - (CW+1)'(br_resolve_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_ARCH; a++)
                map_reg[a] <= PW'(a);
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (br_mispredict_i)
                map_reg <= ckpt_reg[br_ckpt_i];
            else if (fire)
                map_reg <= map_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && take_ckpt)
            ckpt_reg[tail_reg] <= snap_next;
    end

    a_one_branch: assert property (@(posedge clk) disable iff (rst)
        (|ren_valid_i) |-> $onehot0(ren_br_i & ren_valid_i));
    a_resolve_live: assert property (@(posedge clk) disable iff (rst)
        br_resolve_i |-> (count_reg != '0));
    a_mispredict_live: assert property (@(posedge clk) disable iff (rst)
        br_mispredict_i |-> ({1'b0, CW'(br_ckpt_i - head_reg)} < count_reg));
    a_resolve_vs_flush: assert property (@(posedge clk) disable iff (rst)
        (br_resolve_i && br_mispredict_i) |-> (br_ckpt_i != head_reg));

endmodule

// File: tb/tb_rename_map_table.sv
// Scoreboard bench: stimulus queues hand-computed responses, monitor checks each group.
module tb_rename_map_table;
    import rename_map_table_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ren_valid_i, ren_use_rw_i, ren_br_i;
    logic [7:0]  ren_ra_i, ren_rt_i, ren_rw_i;
    logic [11:0] ren_new_p_i;
    logic        ren_ready_o;
    logic [11:0] p_ra_o, p_rt_o, p_old_rw_o;
    logic [1:0]  ckpt_id_o;
    logic        br_resolve_i, br_mispredict_i;
    logic [1:0]  br_ckpt_i;
    logic [2:0]  ckpt_count_o;

    typedef struct packed {
        logic        rdy;
        logic [11:0] p_ra;
        logic [11:0] p_rt;
        logic [11:0] p_old;
        logic [1:0]  cid;
        logic [2:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

`ifdef RENAME_ZERO_REG_EN
    localparam logic [5:0] R0V = 6'd0;
`else
    localparam logic [5:0] R0V = 6'd33;
`endif

    rename_map_table dut (
        .clk             (clk),
        .rst             (rst),
        .ren_valid_i     (ren_valid_i),
        .ren_ra_i        (ren_ra_i),
        .ren_rt_i        (ren_rt_i),
        .ren_rw_i        (ren_rw_i),
        .ren_use_rw_i    (ren_use_rw_i),
        .ren_new_p_i     (ren_new_p_i),
        .ren_br_i        (ren_br_i),
        .ren_ready_o     (ren_ready_o),
        .p_ra_o          (p_ra_o),
        .p_rt_o          (p_rt_o),
        .p_old_rw_o      (p_old_rw_o),
        .ckpt_id_o       (ckpt_id_o),
        .br_resolve_i    (br_resolve_i),
        .br_mispredict_i (br_mispredict_i),
        .br_ckpt_i       (br_ckpt_i),
        .ckpt_count_o    (ckpt_count_o)
    );

    always #5 clk = ~clk;

    function automatic rename_lane_t mk(input int v, input int ra, input int rt, input int rw,
                                        input int use_rw, input int br, input int new_p);
        rename_lane_t l;
        l.valid  = 1'(v);
        l.ra     = arch_reg_t'(ra);
        l.rt     = arch_reg_t'(rt);
        l.rw     = arch_reg_t'(rw);
        l.use_rw = 1'(use_rw);
        l.br     = 1'(br);
        l.new_p  = phys_reg_t'(new_p);
        return l;
    endfunction

    task automatic drive(input rename_lane_t l0, input rename_lane_t l1);
        ren_valid_i  = {l1.valid, l0.valid};
        ren_ra_i     = {l1.ra, l0.ra};
        ren_rt_i     = {l1.rt, l0.rt};
        ren_rw_i     = {l1.rw, l0.rw};
        ren_use_rw_i = {l1.use_rw, l0.use_rw};
        ren_br_i     = {l1.br, l0.br};
        ren_new_p_i  = {l1.new_p, l0.new_p};
    endtask

    // Drives one group for one cycle; any br_* already set applies to the same cycle.
    task automatic issue(input rename_lane_t l0, input rename_lane_t l1, input logic rdy,
                         input logic [5:0] a0, input logic [5:0] a1,
                         input logic [5:0] t0, input logic [5:0] t1,
                         input logic [5:0] o0, input logic [5:0] o1,
                         input logic [1:0] cid, input logic [2:0] cnt);
        exp_t e;
        drive(l0, l1);
        e.rdy   = rdy;
        e.p_ra  = {a1, a0};
        e.p_rt  = {t1, t0};
        e.p_old = {o1, o0};
        e.cid   = cid;
        e.cnt   = cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        br_mispredict_i = 1'b0;
        br_resolve_i    = 1'b0;
    endtask

    task automatic branch_event(input logic mp, input logic res, input logic [1:0] id);
        drive(mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
        br_mispredict_i = mp;
        br_resolve_i    = res;
        br_ckpt_i       = id;
        @(posedge clk);
        #1;
        br_mispredict_i = 1'b0;
        br_resolve_i    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && (|ren_valid_i)) begin
            exp_t act, e;
            act = {ren_ready_o, p_ra_o, p_rt_o, p_old_rw_o, ckpt_id_o, ckpt_count_o};
            n_txn++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL txn%0d unexpected group: got %h, required none", n_txn, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL txn%0d: got rdy=%0b ra=%h rt=%h old=%h id=%0d cnt=%0d, required rdy=%0b ra=%h rt=%h old=%h id=%0d cnt=%0d",
                             n_txn, act.rdy, act.p_ra, act.p_rt, act.p_old, act.cid, act.cnt,
                             e.rdy, e.p_ra, e.p_rt, e.p_old, e.cid, e.cnt);
                end else begin
                    $display("txn%0d ok rdy=%0b ra=%h rt=%h old=%h id=%0d cnt=%0d",
                             n_txn, act.rdy, act.p_ra, act.p_rt, act.p_old, act.cid, act.cnt);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        br_resolve_i = 1'b0;
        br_mispredict_i = 1'b0;
        br_ckpt_i = 2'd0;
        drive(mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // identity map after reset
        issue(mk(1,3,5,0,0,0,0),  mk(1,1,2,0,0,0,0),  1, 3,1,   5,2,  0,0,   0,0);
        // lane0 writes r4, lane1 reads it through the bypass
        issue(mk(1,1,1,4,1,0,40), mk(1,4,6,9,1,0,41), 1, 1,40,  1,6,  4,9,   0,0);
        // both lanes write r7; youngest wins, lane1 old = 50
        issue(mk(1,9,4,7,1,0,50), mk(1,7,0,7,1,0,51), 1, 41,50, 40,0, 7,50,  0,0);
        issue(mk(1,7,4,7,0,0,0),  mk(1,9,3,3,0,0,0),  1, 51,41, 40,3, 51,3,  0,0);
        // branch on lane0 with r2->20, lane1 r2->21 outside the checkpoint
        issue(mk(1,2,1,2,1,1,20), mk(1,2,2,2,1,0,21), 1, 2,20,  1,20, 2,20,  0,0);
        issue(mk(1,2,0,0,0,0,0),  mk(1,7,0,0,0,0,0),  1, 21,51, 0,0,  0,0,   1,1);
        branch_event(1'b1, 1'b0, 2'd0);
        issue(mk(1,2,7,0,0,0,0),  mk(1,4,9,0,0,0,0),  1, 20,40, 51,41, 0,0,  0,0);
        // fill all four checkpoints
        issue(mk(1,1,0,0,0,1,0),  mk(1,3,0,0,0,0,0),  1, 1,3,   0,0,  0,0,   0,0);
        issue(mk(1,0,0,5,1,0,55), mk(1,5,0,0,0,1,0),  1, 0,55,  0,0,  5,0,   1,1);
        issue(mk(1,0,0,0,0,1,0),  mk(1,0,0,0,0,0,0),  1, 0,0,   0,0,  0,0,   2,2);
        issue(mk(1,0,0,0,0,1,0),  mk(1,0,0,0,0,0,0),  1, 0,0,   0,0,  0,0,   3,3);
        // full: branch group stalls, plain group proceeds
        issue(mk(1,0,0,6,1,1,60), mk(1,6,0,0,0,0,0),  0, 0,60,  0,0,  6,0,   0,4);
        issue(mk(1,0,0,6,1,0,61), mk(1,6,0,0,0,0,0),  1, 0,61,  0,0,  6,0,   0,4);
        branch_event(1'b0, 1'b1, 2'd0);
        issue(mk(1,6,0,0,0,0,0),  mk(1,0,0,0,0,0,0),  1, 61,0,  0,0,  0,0,   0,3);
        // mispredict id 2 with a group in the same cycle: group dropped
        br_mispredict_i = 1'b1;
        br_ckpt_i = 2'd2;
        issue(mk(1,5,0,8,1,0,80), mk(1,0,0,0,0,0,0),  0, 55,0,  0,0,  8,0,   0,3);
        issue(mk(1,6,8,0,0,0,0),  mk(1,5,2,0,0,0,0),  1, 6,55,  8,20, 0,0,   2,1);
        branch_event(1'b0, 1'b1, 2'd0);
        // write to r0: renamed normally unless hardwired
        issue(mk(1,4,0,0,1,0,33), mk(1,0,0,0,0,0,0),  1, 40,R0V, 0,R0V, 0,R0V, 2,0);
        issue(mk(1,0,0,0,0,0,0),  mk(1,0,0,0,0,0,0),  1, R0V,R0V, R0V,R0V, R0V,R0V, 2,0);

        drive(mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d unchecked responses, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
